hilo_sequencer: RTL and testbench

- Sits between the control unit and the iterative multiplier/divider, and owns the architectural HI/LO registers.
- Accepts a one-cycle start request and drives the level-sensitive Mult_Control or Div_Control for exactly the unit's iteration count.
- Captures the unit's HI/LO result into the architectural registers and signals Busy/Done so the control unit can stall MFHI/MFLO.
- Also services MTHI/MTLO writes.

---
 rtl/hilo_sequencer.sv | 121 ++++++++++++
 tb/tb_hilo_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hilo_sequencer.sv
// Sequences the iterative multiplier/divider and owns the architectural HI/LO
// registers, including MTHI/MTLO writes and divide-by-zero abort.
module hilo_sequencer #(
  parameter int MULT_LATENCY = 32,
  parameter int DIV_LATENCY  = 32,
  parameter int CNT_W        = 6
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Op,
  output logic        Mult_Control,
  output logic        Div_Control,
  input  logic [31:0] Mult_HI,
  input  logic [31:0] Mult_LO,
  input  logic [31:0] Div_HI,
  input  logic [31:0] Div_LO,
  input  logic        Div_Zero,
  input  logic        HI_Write,
  input  logic        LO_Write,
  input  logic [31:0] Write_Data,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy,
  output logic        Done,
  output logic        Div_By_Zero
);

  typedef enum logic [2:0] {
    IDLE, RUN_MULT, RUN_DIV, CAP_MULT, CAP_DIV, ABORT
  } state_t;

  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_LATENCY - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_LATENCY - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Every output is registered: it is set on the edge that enters the state
  // in which it must be visible.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= IDLE;
      cnt          <= '0;
      HI           <= '0;
      LO           <= '0;
      Mult_Control <= 1'b0;
      Div_Control  <= 1'b0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Div_By_Zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (HI_Write) HI <= Write_Data;
          if (LO_Write) LO <= Write_Data;
          if (Start) begin
            Busy <= 1'b1;
            if (Op) begin
              state       <= RUN_DIV;
              Div_Control <= 1'b1;
            end else begin
              state        <= RUN_MULT;
              Mult_Control <= 1'b1;
            end
          end
        end
        RUN_MULT: begin
          cnt <= cnt + 1'b1;
          if (cnt == MULT_LAST) begin
            state        <= CAP_MULT;
            Mult_Control <= 1'b0;
            Done         <= 1'b1;
          end
        end
        RUN_DIV: begin
          cnt <= cnt + 1'b1;
          // Divide-by-zero wins even on the final iteration.
          if (Div_Zero) begin
            state       <= ABORT;
            Div_Control <= 1'b0;
            Div_By_Zero <= 1'b1;
          end else if (cnt == DIV_LAST) begin
            state       <= CAP_DIV;
            Div_Control <= 1'b0;
            Done        <= 1'b1;
          end
        end
        CAP_MULT: begin
          HI    <= Mult_HI;
          LO    <= Mult_LO;
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        CAP_DIV: begin
          HI    <= Div_HI;
          LO    <= Div_LO;
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        ABORT: begin
          Div_By_Zero <= 1'b0;
          Busy        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state        <= IDLE;
          Mult_Control <= 1'b0;
          Div_Control  <= 1'b0;
          Busy         <= 1'b0;
          Done         <= 1'b0;
          Div_By_Zero  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_sequencer.sv
// Self-checking bench for hilo_sequencer: transaction-level timing model,
// randomized operands, stray Start pulses, MTHI/MTLO writes, abort and reset.
module tb_hilo_sequencer;
  localparam int ML = 32;
  localparam int DL = 32;

  logic        Clock = 1'b0;
  logic        Reset, Start, Op, Div_Zero, HI_Write, LO_Write;
  logic [31:0] Mult_HI, Mult_LO, Div_HI, Div_LO, Write_Data;
  logic        Mult_Control, Div_Control, Busy, Done, Div_By_Zero;
  logic [31:0] HI, LO;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_hi, exp_lo;

  hilo_sequencer #(.MULT_LATENCY(ML), .DIV_LATENCY(DL), .CNT_W(6)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op),
    .Mult_Control(Mult_Control), .Div_Control(Div_Control),
    .Mult_HI(Mult_HI), .Mult_LO(Mult_LO), .Div_HI(Div_HI), .Div_LO(Div_LO),
    .Div_Zero(Div_Zero), .HI_Write(HI_Write), .LO_Write(LO_Write),
    .Write_Data(Write_Data), .HI(HI), .LO(LO), .Busy(Busy), .Done(Done),
    .Div_By_Zero(Div_By_Zero)
  );

  always #5 Clock = ~Clock;

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  // One operation: Start in cycle 0, then every cycle until the first IDLE
  // cycle is checked against timing derived from the latency rules.
  // wr_k: cycle in which an MTHI of 0x12345678 is attempted (-1 = none).
  // zk: cycle in which Div_Zero is raised (0 = none).
  task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input int zk, input int wr_k, input bit stress);
    logic [63:0] p;
    logic [31:0] new_hi, new_lo, hi_e, lo_e;
    int lat, run_end, end_k;
    bit ab;
    lat     = op ? DL : ML;
    ab      = op && (zk > 0);
    run_end = ab ? zk : lat;
    end_k   = ab ? zk + 2 : lat + 2;
    if (op) begin
      new_hi = (b != 0) ? a % b : 32'hFFFF_FFFF;
      new_lo = (b != 0) ? a / b : 32'hFFFF_FFFF;
      Div_HI = new_hi;  Div_LO = new_lo;
      Mult_HI = $urandom; Mult_LO = $urandom;
    end else begin
      p = {32'b0, a} * {32'b0, b};
      new_hi = p[63:32]; new_lo = p[31:0];
      Mult_HI = new_hi; Mult_LO = new_lo;
      Div_HI = $urandom; Div_LO = $urandom;
    end
    n_cmp++;
    if (Busy !== 1'b0) begin
      n_bad++; $display("FAIL idle_before_start: Busy=%b required 0", Busy);
    end
    Op = op; Start = 1'b1; Div_Zero = 1'b0;
    Write_Data = 32'h12345678; HI_Write = (wr_k == 0);
    if (wr_k == 0) exp_hi = 32'h12345678;
    tick;
    for (int k = 1; k <= end_k; k++) begin
      hi_e = (!ab && k >= lat + 2) ? new_hi : exp_hi;
      lo_e = (!ab && k >= lat + 2) ? new_lo : exp_lo;
      n_cmp += 5;
      if (Mult_Control !== (!op && k <= run_end)) begin
        n_bad++; $display("FAIL mult_ctrl k=%0d: got %b required %b", k, Mult_Control, !op && k <= run_end);
      end
      if (Div_Control !== (op && k <= run_end)) begin
        n_bad++; $display("FAIL div_ctrl k=%0d: got %b required %b", k, Div_Control, op && k <= run_end);
      end
      if (Busy !== (k <= run_end + 1)) begin
        n_bad++; $display("FAIL busy k=%0d: got %b required %b", k, Busy, k <= run_end + 1);
      end
      if (Done !== (!ab && k == lat + 1) || Div_By_Zero !== (ab && k == zk + 1)) begin
        n_bad++; $display("FAIL done_dbz k=%0d: got %b/%b required %b/%b", k, Done, Div_By_Zero,
                          !ab && k == lat + 1, ab && k == zk + 1);
      end
      if (HI !== hi_e || LO !== lo_e) begin
        n_bad++; $display("FAIL hilo k=%0d: got %h/%h required %h/%h", k, HI, LO, hi_e, lo_e);
      end
      Start    = stress && (k <= run_end + 1) && ($urandom_range(0, 1) == 1);
      Op       = 1'($urandom);
      Div_Zero = (k == zk);
      HI_Write = (k == wr_k);
      if (k < end_k) tick;
    end
    Start = 1'b0; Div_Zero = 1'b0; HI_Write = 1'b0; LO_Write = 1'b0;
    if (!ab) begin exp_hi = new_hi; exp_lo = new_lo; end
  endtask

  task automatic test_reset;
    Reset = 1'b1; Start = 1'b0; Op = 1'b0; Div_Zero = 1'b0;
    HI_Write = 1'b0; LO_Write = 1'b0; Write_Data = '0;
    Mult_HI = '0; Mult_LO = '0; Div_HI = '0; Div_LO = '0;
    tick; tick;
    n_cmp++;
    if ({Mult_Control, Div_Control, Busy, Done, Div_By_Zero} !== 5'b0 || HI !== 32'h0 || LO !== 32'h0) begin
      n_bad++; $display("FAIL reset_state: ctl=%b HI=%h LO=%h required all zero",
                        {Mult_Control, Div_Control, Busy, Done, Div_By_Zero}, HI, LO);
    end
    Reset = 1'b0; exp_hi = '0; exp_lo = '0;
    tick;
  endtask

  task automatic test_mult_basic;
    run_op(1'b0, 32'd6, 32'd2, 0, -1, 1'b0);
    n_cmp++;
    if (HI !== 32'h0 || LO !== 32'h0000000C) begin
      n_bad++; $display("FAIL mult_6x2: got %h/%h required 00000000/0000000c", HI, LO);
    end
  endtask

  task automatic test_back_to_back;
    run_op(1'b0, 32'h00100400, 32'h00000420, 0, -1, 1'b0);
    n_cmp++;
    if (HI !== 32'h0 || LO !== 32'h42108000) begin
      n_bad++; $display("FAIL mult_big: got %h/%h required 00000000/42108000", HI, LO);
    end
    run_op(1'b0, $urandom, $urandom, 0, -1, 1'b0);
  endtask

  task automatic test_div;
    run_op(1'b1, 32'd100, 32'd7, 0, -1, 1'b0);
    n_cmp++;
    if (HI !== 32'd2 || LO !== 32'd14) begin
      n_bad++; $display("FAIL div_100_7: got %0d/%0d required 2/14", HI, LO);
    end
  endtask

  task automatic test_div_zero;
    HI_Write = 1'b1; Write_Data = 32'hAAAA5555;
    tick;
    HI_Write = 1'b0; exp_hi = 32'hAAAA5555;
    n_cmp++;
    if (HI !== 32'hAAAA5555) begin
      n_bad++; $display("FAIL preload_hi: got %h required aaaa5555", HI);
    end
    run_op(1'b1, 32'd5, 32'd0, 5, -1, 1'b0);
  endtask

  task automatic test_writes;
    run_op(1'b0, $urandom, $urandom, 0, 10, 1'b1);
    Write_Data = 32'h12345678; HI_Write = 1'b1;
    tick;
    HI_Write = 1'b0;
    n_cmp++;
    if (HI !== 32'h12345678 || LO !== exp_lo) begin
      n_bad++; $display("FAIL mthi: got %h/%h required 12345678/%h", HI, LO, exp_lo);
    end
    Write_Data = $urandom; LO_Write = 1'b1;
    exp_lo = Write_Data;
    tick;
    LO_Write = 1'b0;
    n_cmp++;
    if (HI !== 32'h12345678 || LO !== exp_lo) begin
      n_bad++; $display("FAIL mtlo: got %h/%h required 12345678/%h", HI, LO, exp_lo);
    end
    Write_Data = $urandom; HI_Write = 1'b1; LO_Write = 1'b1;
    exp_hi = Write_Data; exp_lo = Write_Data;
    tick;
    HI_Write = 1'b0; LO_Write = 1'b0;
    n_cmp++;
    if (HI !== exp_hi || LO !== exp_lo) begin
      n_bad++; $display("FAIL mt_both: got %h/%h required %h/%h", HI, LO, exp_hi, exp_lo);
    end
    run_op(1'b1, $urandom, $urandom_range(1, 1000), 0, 0, 1'b0);
  endtask

  task automatic test_reset_mid;
    Op = 1'b0; Start = 1'b1;
    tick;
    Start = 1'b0;
    repeat (14) tick;
    n_cmp++;
    if (Mult_Control !== 1'b1 || Busy !== 1'b1) begin
      n_bad++; $display("FAIL mid_op_cycle15: ctl=%b busy=%b required 1/1", Mult_Control, Busy);
    end
    Reset = 1'b1;
    tick;
    Reset = 1'b0; exp_hi = '0; exp_lo = '0;
    n_cmp++;
    if ({Mult_Control, Div_Control, Busy, Done, Div_By_Zero} !== 5'b0 || HI !== 32'h0 || LO !== 32'h0) begin
      n_bad++; $display("FAIL reset_mid_op: ctl=%b HI=%h LO=%h required all zero",
                        {Mult_Control, Div_Control, Busy, Done, Div_By_Zero}, HI, LO);
    end
    run_op(1'b0, $urandom, $urandom, 0, -1, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 20; i++) begin
      logic op;
      int zk, wk;
      op = 1'($urandom);
      zk = (op && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, DL)) : 0;
      wk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1;
      run_op(op, $urandom, (op && $urandom_range(0, 1) == 1) ? $urandom_range(1, 50) : $urandom,
             zk, wk, 1'($urandom));
    end
  endtask

  initial begin
    test_reset;
    test_mult_basic;
    test_back_to_back;
    test_div;
    test_div_zero;
    test_writes;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
